// File: rtl/line_mem_pkg.sv
// -----------------------------------------------------------------------------
// line_mem_pkg
// Shared definitions for the cache line-fill / write-back memory responder.
// It holds the FSM state encoding, the line geometry and the helper that forms
// a RAM byte address from a line address and a beat index.
// -----------------------------------------------------------------------------
package line_mem_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam logic [DATA_WIDTH-1:0] ZeroWord = '0;

    localparam int LINE_WORDS  = 8;
    localparam int BEAT_W      = 3;
    localparam int LINE_W      = 256;
    localparam int LINE_ADDR_W = ADDR_WIDTH - 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB      = 3'd1,
        ST_RD      = 3'd2,
        ST_RD_LAST = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Byte address of word 'beat' within the 32-byte line 'line'.
    function automatic logic [ADDR_WIDTH-1:0] line_addr(
        input logic [LINE_ADDR_W-1:0] line,
        input logic [BEAT_W-1:0]      beat
    );
        return {line, beat, 2'b00};
    endfunction

endpackage

// File: rtl/line_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// line_mem_ctrl_if
// Cache-side request/response bundle of the line memory controller.
//   req_read     refill the line at req_addr
//   req_write    write back req_wdata to the line at req_wb_addr
//   req_addr     refill byte address (bits [4:0] ignored)
//   req_wb_addr  victim byte address (bits [4:0] ignored)
//   req_wdata    victim line, word k = bits [32k+31:32k]
//   resp_rdata   refilled line, held until the next refill completes
//   resp_valid   one-cycle completion pulse
//   busy         controller is not idle
// master = the cache (requester), slave = the controller.
// -----------------------------------------------------------------------------
interface line_mem_ctrl_if;
    import line_mem_pkg::*;

    logic                    req_read;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [ADDR_WIDTH-1:0]   req_wb_addr;
    logic [LINE_W-1:0]       req_wdata;
    logic [LINE_W-1:0]       resp_rdata;
    logic                    resp_valid;
    logic                    busy;

    modport master (
        output req_read, req_write, req_addr, req_wb_addr, req_wdata,
        input  resp_rdata, resp_valid, busy
    );

    modport slave (
        input  req_read, req_write, req_addr, req_wb_addr, req_wdata,
        output resp_rdata, resp_valid, busy
    );

endinterface

// File: rtl/line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// 8 x 32-bit register file used to assemble a refilled line word by word.
//   clk      clock (rising edge)
//   i_we     write enable for one word
//   i_idx    word index to write
//   i_wdata  word to write
//   o_line   flat view of all words, word k = bits [32k+31:32k]
// Contents are pure data and are not reset.
// -----------------------------------------------------------------------------
module line_buffer
    import line_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [BEAT_W-1:0]     i_idx,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [LINE_W-1:0]     o_line
);

    logic [DATA_WIDTH-1:0] r_mem [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_view
        assign o_line[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[k];
    end

endmodule

// File: rtl/line_mem_ctrl.sv
// -----------------------------------------------------------------------------
// line_mem_ctrl
// Memory-side responder for the data cache line port. Takes one 256-bit line
// request at a time (write-back, refill, or write-back then refill) and
// serialises it onto a 32-bit synchronous RAM with one-cycle read latency.
//   CLK        clock, rising edge
//   RST_N      synchronous active-low reset
//   bus        cache-side request/response bundle (slave side)
//   ram_en     RAM access strobe (registered)
//   ram_we     1 = write, 0 = read, qualified by ram_en (registered)
//   ram_addr   RAM byte address {line, beat, 2'b00} (registered)
//   ram_wdata  RAM write word (registered)
//   ram_rdata  RAM read word, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module line_mem_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int RAM_RD_LAT = 1
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    line_mem_ctrl_if.slave                     bus,
    output logic                               ram_en,
    output logic                               ram_we,
    output logic [line_mem_pkg::ADDR_WIDTH-1:0] ram_addr,
    output logic [line_mem_pkg::DATA_WIDTH-1:0] ram_wdata,
    input  logic [line_mem_pkg::DATA_WIDTH-1:0] ram_rdata
);
    import line_mem_pkg::*;

    if (LINE_WORDS != 8 || RAM_RD_LAT != 1) begin : g_param_check
        $error("line_mem_ctrl supports only LINE_WORDS=8 and RAM_RD_LAT=1");
    end

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [BEAT_W-1:0]       r_beat;
    logic [BEAT_W-1:0]       w_beat_nxt;
    logic                    r_rd_op;
    logic [LINE_ADDR_W-1:0]  r_wb_line;
    logic [LINE_ADDR_W-1:0]  r_rd_line;
    logic [LINE_W-1:0]       r_wdata;
    logic                    r_pend;
    logic [BEAT_W-1:0]       r_pend_idx;
    logic                    r_ram_en;
    logic                    r_ram_we;
    logic [ADDR_WIDTH-1:0]   r_ram_addr;
    logic [DATA_WIDTH-1:0]   r_ram_wdata;
    logic [LINE_W-1:0]       r_resp_rdata;

    logic                    w_req;
    logic                    w_accept;
    logic                    w_last_beat;
    logic [LINE_ADDR_W-1:0]  w_wb_line_nxt;
    logic [LINE_ADDR_W-1:0]  w_rd_line_nxt;
    logic [LINE_W-1:0]       w_wdata_nxt;
    logic                    w_ram_en_nxt;
    logic                    w_ram_we_nxt;
    logic [ADDR_WIDTH-1:0]   w_ram_addr_nxt;
    logic [DATA_WIDTH-1:0]   w_ram_wdata_nxt;
    logic [LINE_W-1:0]       w_buf_line;
    logic                    w_unused;

    assign w_unused    = ^{bus.req_addr[4:0], bus.req_wb_addr[4:0]};

    assign w_req       = bus.req_read | bus.req_write;
    assign w_accept    = (r_state == ST_IDLE) && w_req;
    assign w_last_beat = (r_beat == BEAT_W'(LINE_WORDS - 1));

    // Values the capture registers will hold next cycle; the RAM outputs are
    // registered, so the first beat must be formed from the live request.
    assign w_wb_line_nxt = w_accept ? bus.req_wb_addr[ADDR_WIDTH-1:5] : r_wb_line;
    assign w_rd_line_nxt = w_accept ? bus.req_addr[ADDR_WIDTH-1:5]    : r_rd_line;
    assign w_wdata_nxt   = w_accept ? bus.req_wdata                   : r_wdata;

    // Next state and beat. The beat counter is cleared in IDLE and wraps
    // 7 -> 0 on the last beat, so every state starts at beat 0.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = bus.req_write ? ST_WB : ST_RD;
                end
            end
            ST_WB: begin
                w_beat_nxt = r_beat + BEAT_W'(1);
                if (w_last_beat) begin
                    w_state_nxt = r_rd_op ? ST_RD : ST_DONE;
                end
            end
            ST_RD: begin
                w_beat_nxt = r_beat + BEAT_W'(1);
                if (w_last_beat) begin
                    w_state_nxt = ST_RD_LAST;
                end
            end
            ST_RD_LAST: w_state_nxt = ST_DONE;
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // RAM drive for the coming cycle, derived from the next state and beat.
    always_comb begin
        w_ram_en_nxt    = 1'b0;
        w_ram_we_nxt    = 1'b0;
        w_ram_addr_nxt  = ZeroWord;
        w_ram_wdata_nxt = ZeroWord;
        case (w_state_nxt)
            ST_WB: begin
                w_ram_en_nxt    = 1'b1;
                w_ram_we_nxt    = 1'b1;
                w_ram_addr_nxt  = line_addr(w_wb_line_nxt, w_beat_nxt);
                w_ram_wdata_nxt = w_wdata_nxt[int'(w_beat_nxt)*DATA_WIDTH +: DATA_WIDTH];
            end
            ST_RD: begin
                w_ram_en_nxt   = 1'b1;
                w_ram_addr_nxt = line_addr(w_rd_line_nxt, w_beat_nxt);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= ST_IDLE;
            r_beat       <= '0;
            r_rd_op      <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_idx   <= '0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= ZeroWord;
            r_ram_wdata  <= ZeroWord;
            r_resp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat      <= w_beat_nxt;
            if (w_accept) begin
                r_rd_op <= bus.req_read;
            end
            // A read issued this cycle returns data next cycle into slot r_beat.
            r_pend      <= (r_state == ST_RD);
            r_pend_idx  <= r_beat;
            r_ram_en    <= w_ram_en_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            // In RD_LAST the last word is still on ram_rdata and lands in the
            // buffer at this same edge, so merge it directly into the response.
            if (r_state == ST_RD_LAST) begin
                r_resp_rdata <= {ram_rdata, w_buf_line[LINE_W-DATA_WIDTH-1:0]};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_wb_line <= bus.req_wb_addr[ADDR_WIDTH-1:5];
            r_rd_line <= bus.req_addr[ADDR_WIDTH-1:5];
            r_wdata   <= bus.req_wdata;
        end
    end

    line_buffer u_line_buffer (
        .clk     (CLK),
        .i_we    (r_pend),
        .i_idx   (r_pend_idx),
        .i_wdata (ram_rdata),
        .o_line  (w_buf_line)
    );

    assign ram_en         = r_ram_en;
    assign ram_we         = r_ram_we;
    assign ram_addr       = r_ram_addr;
    assign ram_wdata      = r_ram_wdata;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_valid = (r_state == ST_DONE);
    assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_line_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_mem_ctrl
// Directed bench for line_mem_ctrl with a behavioural word RAM and a scoreboard
// of expected RAM operations and responses (each tagged with its cycle).
// -----------------------------------------------------------------------------
module tb_line_mem_ctrl;

    typedef struct packed {
        logic [31:0] cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ram_op_t;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [255:0] data;
    } rsp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic [31:0] mem [256];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int t;

    ram_op_t exp_ram[$];
    ram_op_t obs_ram[$];
    rsp_t    exp_rsp[$];
    rsp_t    obs_rsp[$];
    logic [255:0] last_line;

    line_mem_ctrl_if bus ();

    line_mem_ctrl #(
        .LINE_WORDS (8),
        .RAM_RD_LAT (1)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr[9:2]];
        end
    end

    // Observe DUT outputs mid-cycle.
    always @(negedge clk) begin
        if (ram_en === 1'b1)
            obs_ram.push_back('{cyc: cyc, we: ram_we, addr: ram_addr,
                                wdata: (ram_we ? ram_wdata : 32'h0)});
        if (bus.resp_valid === 1'b1)
            obs_rsp.push_back('{cyc: cyc, data: bus.resp_rdata});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [255:0] mkline(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ops(input int c0, input logic we, input logic [31:0] a0,
                            input logic [31:0] d0, input int n);
        for (int k = 0; k < n; k++)
            exp_ram.push_back('{cyc: c0 + k, we: we, addr: a0 + 32'(4*k),
                                wdata: (we ? d0 + 32'(k) : 32'h0)});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the DUT to produce what was expected, then score.
    task automatic run_check(input string tag, input int budget);
        ram_op_t e;
        ram_op_t o;
        rsp_t    er;
        rsp_t    orr;
        for (int i = 0; i < budget; i++) begin
            if (obs_ram.size() >= exp_ram.size() && obs_rsp.size() >= exp_rsp.size()) break;
            next_cycle();
        end
        while (exp_ram.size() > 0 && obs_ram.size() > 0) begin
            e = exp_ram.pop_front();
            o = obs_ram.pop_front();
            check({tag, "_ram_cyc"}, 256'(o.cyc), 256'(e.cyc));
            check({tag, "_ram_op"}, 256'({o.we, o.addr, o.wdata}), 256'({e.we, e.addr, e.wdata}));
        end
        while (exp_rsp.size() > 0 && obs_rsp.size() > 0) begin
            er  = exp_rsp.pop_front();
            orr = obs_rsp.pop_front();
            check({tag, "_rsp_cyc"}, 256'(orr.cyc), 256'(er.cyc));
            check({tag, "_rsp_data"}, orr.data, er.data);
        end
        check({tag, "_ram_left"}, 256'(exp_ram.size() + obs_ram.size()), 256'(0));
        check({tag, "_rsp_left"}, 256'(exp_rsp.size() + obs_rsp.size()), 256'(0));
        exp_ram.delete();
        obs_ram.delete();
        exp_rsp.delete();
        obs_rsp.delete();
        check({tag, "_idle_busy"}, 256'(bus.busy), 256'(0));
    endtask

    initial begin
        bus.req_read    = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = 32'h0;
        bus.req_wb_addr = 32'h0;
        bus.req_wdata   = '0;
        last_line       = '0;
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        for (int k = 0; k < 8; k++) mem[(32'h100 >> 2) + k] = 32'hA0 + 32'(k);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_en", 256'(ram_en), 256'(0));
        check("rst_ram_we", 256'(ram_we), 256'(0));
        check("rst_ram_addr", 256'(ram_addr), 256'(0));
        check("rst_ram_wdata", 256'(ram_wdata), 256'(0));
        check("rst_busy", 256'(bus.busy), 256'(0));
        check("rst_resp_valid", 256'(bus.resp_valid), 256'(0));
        check("rst_resp_rdata", bus.resp_rdata, 256'(0));
        rst_n = 1'b1;
        next_cycle();

        // Read-only refill of line 0x100 (low address bits ignored)
        t = cyc;
        push_ops(t + 1, 1'b0, 32'h100, 32'h0, 8);
        last_line = mkline(32'hA0);
        exp_rsp.push_back('{cyc: t + 10, data: last_line});
        bus.req_read = 1'b1;
        bus.req_addr = 32'h11F;
        next_cycle();
        bus.req_read = 1'b0;
        run_check("rd", 40);

        // Write-only; response data must be unchanged
        t = cyc;
        push_ops(t + 1, 1'b1, 32'h200, 32'h5000, 8);
        exp_rsp.push_back('{cyc: t + 9, data: last_line});
        bus.req_write   = 1'b1;
        bus.req_wb_addr = 32'h200;
        bus.req_wdata   = mkline(32'h5000);
        next_cycle();
        bus.req_write = 1'b0;
        run_check("wr", 40);

        // Write-back then refill of the same line
        t = cyc;
        push_ops(t + 1, 1'b1, 32'h300, 32'hC0, 8);
        push_ops(t + 9, 1'b0, 32'h300, 32'h0, 8);
        last_line = mkline(32'hC0);
        exp_rsp.push_back('{cyc: t + 18, data: last_line});
        bus.req_write   = 1'b1;
        bus.req_read    = 1'b1;
        bus.req_wb_addr = 32'h300;
        bus.req_addr    = 32'h300;
        bus.req_wdata   = mkline(32'hC0);
        next_cycle();
        bus.req_write = 1'b0;
        bus.req_read  = 1'b0;
        run_check("wrrd", 60);

        // Request inputs wiggling while busy are ignored
        t = cyc;
        push_ops(t + 1, 1'b0, 32'h100, 32'h0, 8);
        last_line = mkline(32'hA0);
        exp_rsp.push_back('{cyc: t + 10, data: last_line});
        bus.req_read = 1'b1;
        bus.req_addr = 32'h100;
        next_cycle();
        bus.req_read = 1'b0;
        next_cycle();
        next_cycle();
        bus.req_addr = 32'h200;
        bus.req_read = 1'b1;
        next_cycle();
        bus.req_read = 1'b0;
        next_cycle();
        bus.req_read    = 1'b1;
        bus.req_write   = 1'b1;
        bus.req_wb_addr = 32'h000;
        next_cycle();
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        run_check("busy", 40);

        // Reset during write-back beat 3
        t = cyc;
        push_ops(t + 1, 1'b1, 32'h200, 32'h7000, 4);
        bus.req_write   = 1'b1;
        bus.req_wb_addr = 32'h200;
        bus.req_wdata   = mkline(32'h7000);
        next_cycle();
        bus.req_write = 1'b0;
        repeat (3) next_cycle();
        rst_n = 1'b0;
        next_cycle();
        check("abort_ram_en", 256'(ram_en), 256'(0));
        check("abort_ram_we", 256'(ram_we), 256'(0));
        check("abort_ram_addr", 256'(ram_addr), 256'(0));
        check("abort_ram_wdata", 256'(ram_wdata), 256'(0));
        check("abort_busy", 256'(bus.busy), 256'(0));
        check("abort_resp_valid", 256'(bus.resp_valid), 256'(0));
        check("abort_resp_rdata", bus.resp_rdata, 256'(0));
        rst_n = 1'b1;
        repeat (6) next_cycle();
        run_check("abort", 4);

        // Fresh read-only request after the abort
        t = cyc;
        push_ops(t + 1, 1'b0, 32'h300, 32'h0, 8);
        last_line = mkline(32'hC0);
        exp_rsp.push_back('{cyc: t + 10, data: last_line});
        bus.req_read = 1'b1;
        bus.req_addr = 32'h300;
        next_cycle();
        bus.req_read = 1'b0;
        run_check("post_rst", 40);

        // Request held through DONE is accepted a second time
        t = cyc;
        push_ops(t + 1, 1'b0, 32'h100, 32'h0, 8);
        push_ops(t + 12, 1'b0, 32'h100, 32'h0, 8);
        last_line = mkline(32'hA0);
        exp_rsp.push_back('{cyc: t + 10, data: last_line});
        exp_rsp.push_back('{cyc: t + 21, data: last_line});
        bus.req_read = 1'b1;
        bus.req_addr = 32'h100;
        repeat (12) next_cycle();
        bus.req_read = 1'b0;
        run_check("held", 40);

        // Nothing further may appear once idle
        repeat (15) next_cycle();
        check("final_quiet", 256'(obs_ram.size() + obs_rsp.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
